// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK bank controller.
// Holds the 3-bit command opcodes and the controller state encoding.
package jk_ctrl_pkg;

  localparam logic [2:0] OP_HOLD   = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_SET    = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_INC    = 3'd5;
  localparam logic [2:0] OP_DEC    = 3'd6;
  localparam logic [2:0] OP_ILL    = 3'd7;

  typedef enum logic [2:0] {
    StInit,
    StInitChk,
    StIdle,
    StApply,
    StCheck,
    StResp
  } state_e;

endpackage

// File: rtl/jk_excite.sv
// Combinational J/K excitation decoder.
// Maps an opcode, operand and the current bank value to the J/K pattern
// that reaches the target value in one clock, plus the expected result.
// Ports:
//   op, data, cur : opcode, operand, last sampled bank value
//   j, k          : excitation for the bank
//   exp           : value the bank should hold after the update
//   illegal       : opcode is not a defined command
module jk_excite import jk_ctrl_pkg::*; #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] exp,
  output logic             illegal
);

  logic [WIDTH-1:0] one;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] dec;

  assign one = {{(WIDTH-1){1'b0}}, 1'b1};
  assign inc = cur + one;
  assign dec = cur - one;

  always_comb begin
    j       = '0;
    k       = '0;
    exp     = cur;
    illegal = 1'b0;
    unique case (op)
      OP_HOLD: ;
      OP_LOAD: begin
        j   = data;
        k   = ~data;
        exp = data;
      end
      OP_CLEAR: begin
        k   = '1;
        exp = '0;
      end
      OP_SET: begin
        j   = '1;
        exp = '1;
      end
      OP_TOGGLE: begin
        j   = data;
        k   = data;
        exp = cur ^ data;
      end
      // Toggle exactly the bits that change, so the carry ripple lands in one edge.
      OP_INC: begin
        j   = cur ^ inc;
        k   = cur ^ inc;
        exp = inc;
      end
      OP_DEC: begin
        j   = cur ^ dec;
        k   = cur ^ dec;
        exp = dec;
      end
      OP_ILL: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Sequencing controller for a bank of reset-less JK flip-flops.
// Clears the bank after reset, then turns each accepted command into a
// single-cycle J/K excitation, reads the bank back, verifies it and returns
// the sampled value on a valid/ready response channel.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   cmd_valid/ready/op/data  : command channel
//   rsp_valid/ready/q/err    : response channel
//   busy                     : not idle
//   init_err                 : sticky post-reset clear failure
//   jk_j, jk_k               : registered bank excitation
//   bank_q, bank_qbar        : bank outputs
module jk_bank_ctrl import jk_ctrl_pkg::*; #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_q,
  output logic             rsp_err,
  output logic             busy,
  output logic             init_err,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  input  logic [WIDTH-1:0] bank_q,
  input  logic [WIDTH-1:0] bank_qbar
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] jk_j_q, jk_j_d;
  logic [WIDTH-1:0] jk_k_q, jk_k_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             ill_q, ill_d;
  logic [WIDTH-1:0] rsp_q_q, rsp_q_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             cmd_ready_q, busy_q;
  logic             init_err_q, init_err_d;

  logic [WIDTH-1:0] ex_j, ex_k, ex_exp;
  logic             ex_ill;

  jk_excite #(
    .WIDTH(WIDTH)
  ) u_excite (
    .op     (cmd_op),
    .data   (cmd_data),
    .cur    (cur_q),
    .j      (ex_j),
    .k      (ex_k),
    .exp    (ex_exp),
    .illegal(ex_ill)
  );

  always_comb begin
    state_d     = state_q;
    jk_j_d      = '0;
    jk_k_d      = '0;
    cur_d       = cur_q;
    exp_d       = exp_q;
    ill_d       = ill_q;
    rsp_q_d     = rsp_q_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    init_err_d  = init_err_q;
    case (state_q)
      StInit: state_d = StInitChk;
      StInitChk: begin
        if (bank_q != '0) init_err_d = 1'b1;
        cur_d   = bank_q;
        state_d = StIdle;
      end
      StIdle: begin
        if (cmd_valid) begin
          jk_j_d  = ex_j;
          jk_k_d  = ex_k;
          exp_d   = ex_exp;
          ill_d   = ex_ill;
          state_d = StApply;
        end
      end
      StApply: state_d = StCheck;
      StCheck: begin
        rsp_q_d     = bank_q;
        rsp_err_d   = (bank_q != exp_q) | (bank_qbar != ~bank_q) | ill_q;
        cur_d       = bank_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // jk_k resets to all ones so the bank clears on every edge while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StInit;
      jk_j_q      <= '0;
      jk_k_q      <= '1;
      cur_q       <= '0;
      exp_q       <= '0;
      ill_q       <= 1'b0;
      rsp_q_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      init_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      jk_j_q      <= jk_j_d;
      jk_k_q      <= jk_k_d;
      cur_q       <= cur_d;
      exp_q       <= exp_d;
      ill_q       <= ill_d;
      rsp_q_q     <= rsp_q_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= (state_d == StIdle);
      busy_q      <= (state_d != StIdle);
      init_err_q  <= init_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_err   = rsp_err_q;
  assign init_err  = init_err_q;
  assign jk_j      = jk_j_q;
  assign jk_k      = jk_k_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed self-checking bench for jk_bank_ctrl driving a behavioural JK bank
// with stuck-at injection on the bank outputs.
module tb_jk_bank_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_q;
  logic         rsp_err, busy, init_err;
  logic [W-1:0] jk_j, jk_k, bank_q, bank_qbar;

  logic [W-1:0] cells;
  logic [W-1:0] stuck0 = '0;
  logic [W-1:0] stuck1 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reset-less JK cells
  always @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      case ({jk_j[i], jk_k[i]})
        2'b10:   cells[i] <= 1'b1;
        2'b01:   cells[i] <= 1'b0;
        2'b11:   cells[i] <= ~cells[i];
        default: cells[i] <= cells[i];
      endcase
    end
  end

  assign bank_q    = (cells | stuck1) & ~stuck0;
  assign bank_qbar = ~bank_q;

  jk_bank_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_q    (rsp_q),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .init_err (init_err),
    .jk_j     (jk_j),
    .jk_k     (jk_k),
    .bank_q   (bank_q),
    .bank_qbar(bank_qbar)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One full command: acceptance, APPLY, CHECK, RESP, handshake.
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [W-1:0] data,
                        input logic [W-1:0] ej, input logic [W-1:0] ek,
                        input logic [W-1:0] eq, input logic eerr);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge clk);  // APPLY
    cmd_valid = 1'b0;
    chk({tag, " j"}, 32'(jk_j), 32'(ej));
    chk({tag, " k"}, 32'(jk_k), 32'(ek));
    chk({tag, " busy"}, 32'(busy), 32'd1);
    @(negedge clk);  // CHECK
    chk({tag, " early valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " j hold"}, 32'({jk_j, jk_k}), 32'd0);
    @(negedge clk);  // RESP
    chk({tag, " valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " rsp_q"}, 32'(rsp_q), 32'(eq));
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'(eerr));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " valid drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, " idle"}, 32'(cmd_ready), 32'd1);
  endtask

  // Reset for three clocks, release, and check the two-clock init sequence.
  task automatic do_reset(input string tag, input logic eie);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, " rst k"}, 32'(jk_k), 32'hFF);
    chk({tag, " rst j"}, 32'(jk_j), 32'h00);
    chk({tag, " rst ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, " rst busy"}, 32'(busy), 32'd1);
    chk({tag, " rst valid"}, 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk({tag, " initchk k"}, 32'(jk_k), 32'h00);
    chk({tag, " initchk ready"}, 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk({tag, " ready 2clk"}, 32'(cmd_ready), 32'd1);
    chk({tag, " busy low"}, 32'(busy), 32'd0);
    chk({tag, " init_err"}, 32'(init_err), 32'(eie));
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = '0;
    rsp_ready = 1'b0;

    do_reset("por", 1'b0);
    chk("por bank", 32'(bank_q), 32'h00);

    do_cmd("load a5", 3'd1, 8'hA5, 8'hA5, 8'h5A, 8'hA5, 1'b0);
    do_cmd("toggle 0f", 3'd4, 8'h0F, 8'h0F, 8'h0F, 8'hAA, 1'b0);
    do_cmd("set", 3'd3, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0);
    do_cmd("inc wrap", 3'd5, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0);
    do_cmd("dec wrap", 3'd6, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    do_cmd("load 7f", 3'd1, 8'h7F, 8'h7F, 8'h80, 8'h7F, 1'b0);
    do_cmd("inc 7f", 3'd5, 8'h00, 8'hFF, 8'hFF, 8'h80, 1'b0);
    do_cmd("hold", 3'd0, 8'h33, 8'h00, 8'h00, 8'h80, 1'b0);
    do_cmd("clear", 3'd2, 8'h33, 8'h00, 8'hFF, 8'h00, 1'b0);
    do_cmd("load 3c", 3'd1, 8'h3C, 8'h3C, 8'hC3, 8'h3C, 1'b0);
    do_cmd("illegal", 3'd7, 8'h55, 8'h00, 8'h00, 8'h3C, 1'b1);

    // Bit 2 stuck at 0: cells go to FF but the bank reads FB.
    stuck0 = 8'h04;
    do_cmd("stuck load", 3'd1, 8'hFF, 8'hFF, 8'h00, 8'hFB, 1'b1);
    stuck0 = 8'h00;
    // cur must now be FB: INC toggles FB^FC=07, cells FF->F8, expected FC.
    do_cmd("cur after err", 3'd5, 8'h00, 8'h07, 8'h07, 8'hF8, 1'b1);

    // Backpressure: response held for 5 clocks while cmd_valid stays high.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_data  = 8'h12;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", 32'(rsp_valid), 32'd1);
      chk("bp rsp_q", 32'(rsp_q), 32'h12);
      chk("bp no accept", 32'({cmd_ready, busy}), 32'b01);
      @(negedge clk);
    end
    chk("bp still resp", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("bp released", 32'(rsp_valid), 32'd0);
    chk("bp idle", 32'(cmd_ready), 32'd1);

    // Reset during APPLY aborts the command.
    cmd_valid = 1'b1;
    cmd_op    = 3'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort apply j", 32'(jk_j), 32'hFF);
    rst = 1'b1;
    #1;
    chk("abort k", 32'(jk_k), 32'hFF);
    chk("abort busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort no valid", 32'(rsp_valid), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("abort initchk", 32'({cmd_ready, rsp_valid}), 32'd0);
    @(negedge clk);
    chk("abort ready", 32'(cmd_ready), 32'd1);
    chk("abort bank", 32'(bank_q), 32'h00);
    chk("abort init_err", 32'(init_err), 32'd0);

    // Reset while a response is pending drops it at once.
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_data  = 8'h66;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    chk("drop pre valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("drop valid", 32'(rsp_valid), 32'd0);
    do_reset("drop", 1'b0);

    // Bit 0 stuck at 1 through reset: clear fails to verify.
    stuck1 = 8'h01;
    do_reset("stuck init", 1'b1);
    stuck1 = 8'h00;
    do_cmd("after init err", 3'd1, 8'h55, 8'h55, 8'hAA, 8'h55, 1'b0);
    chk("init_err sticky", 32'(init_err), 32'd1);
    do_reset("clear init_err", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
